// File: rtl/pipeline_run_ctrl.sv
// Execution controller for a 5-stage pipeline: gates the global enable, runs in
// free-running or single-step mode, and drains the pipeline after a decoded HALT.
module pipeline_run_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_run,
  input  logic             i_cmd_step,
  input  logic             i_cmd_stop,
  input  logic             i_cmd_clear,
  input  logic             i_halt_decoded,
  output logic             o_pipe_enable,
  output logic             o_fetch_kill,
  output logic             o_pipe_flush,
  output logic             o_halted,
  output logic             o_step_done,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  // Commands are single-cycle pulses with no ready/acknowledge: a command is
  // consumed on the edge that samples it, or dropped if the state ignores it.
  state_t          state_q;
  logic [DC_W-1:0] drain_q;
  logic            from_step_q;
  logic            enable_q;
  logic            flush_q;
  logic            halted_q;
  logic            step_done_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            clear_acc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      from_step_q <= 1'b0;
      enable_q    <= 1'b0;
      flush_q     <= 1'b0;
      halted_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      flush_q     <= 1'b0;
      step_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_cmd_clear) begin
            flush_q <= 1'b1;
          end else if (i_cmd_run) begin
            state_q  <= S_RUN;
            enable_q <= 1'b1;
          end else if (i_cmd_step) begin
            state_q  <= S_STEP;
            enable_q <= 1'b1;
          end
        end
        S_RUN: begin
          // A HALT in ID wins over stop so the program always drains cleanly.
          if (i_halt_decoded) begin
            state_q     <= S_DRAIN;
            drain_q     <= DC_W'(DRAIN_CYCLES);
            from_step_q <= 1'b0;
          end else if (i_cmd_stop) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
          end
        end
        S_STEP: begin
          if (i_halt_decoded) begin
            state_q     <= S_DRAIN;
            drain_q     <= DC_W'(DRAIN_CYCLES);
            from_step_q <= 1'b1;
          end else begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            step_done_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == DC_W'(1)) begin
            state_q     <= S_HALTED;
            enable_q    <= 1'b0;
            halted_q    <= 1'b1;
            step_done_q <= from_step_q;
          end else begin
            drain_q <= drain_q - DC_W'(1);
          end
        end
        S_HALTED: begin
          if (i_cmd_clear) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
            flush_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          enable_q <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign clear_acc = i_cmd_clear && ((state_q == S_IDLE) || (state_q == S_HALTED));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_acc) begin
      cnt_d = '0;
    end else if (enable_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so the instruction fetched during the HALT-decode cycle is squashed.
  assign o_fetch_kill  = (((state_q == S_RUN) || (state_q == S_STEP)) && i_halt_decoded) ||
                         (state_q == S_DRAIN);
  assign o_pipe_enable = enable_q;
  assign o_pipe_flush  = flush_q;
  assign o_halted      = halted_q;
  assign o_step_done   = step_done_q;
  assign o_state       = state_q;
  assign o_cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed scenarios followed by random command
// traffic, all checked against a timeline model of run/step/drain/halt behaviour.
module tb_pipeline_run_ctrl;

  localparam int DRAIN = 3;
  localparam int CW    = 32;
  localparam longint CNT_MAX = (64'd1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear, i_halt_decoded;
  logic          o_pipe_enable, o_fetch_kill, o_pipe_flush, o_halted, o_step_done;
  logic [2:0]    o_state;
  logic [CW-1:0] o_cycle_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: mode flags plus a countdown of remaining drain cycles.
  bit     m_running, m_stepping, m_halted, m_from_step, m_flush, m_done;
  int     m_drain_left;
  longint m_cnt;

  pipeline_run_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_cmd_run      (i_cmd_run),
    .i_cmd_step     (i_cmd_step),
    .i_cmd_stop     (i_cmd_stop),
    .i_cmd_clear    (i_cmd_clear),
    .i_halt_decoded (i_halt_decoded),
    .o_pipe_enable  (o_pipe_enable),
    .o_fetch_kill   (o_fetch_kill),
    .o_pipe_flush   (o_pipe_flush),
    .o_halted       (o_halted),
    .o_step_done    (o_step_done),
    .o_state        (o_state),
    .o_cycle_cnt    (o_cycle_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_en();
    return m_running || m_stepping || (m_drain_left > 0);
  endfunction

  function automatic logic [2:0] model_state();
    if (m_halted) return 3'd4;
    if (m_drain_left > 0) return 3'd3;
    if (m_stepping) return 3'd2;
    if (m_running) return 3'd1;
    return 3'd0;
  endfunction

  function automatic bit model_kill(input bit halt);
    return ((m_running || m_stepping) && halt) || (m_drain_left > 0);
  endfunction

  task automatic model_reset();
    m_running = 0; m_stepping = 0; m_halted = 0; m_from_step = 0;
    m_flush = 0; m_done = 0; m_drain_left = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit run, input bit step, input bit stop,
                            input bit clear, input bit halt);
    bit en;
    en = model_en();
    m_flush = 0;
    m_done  = 0;
    if (m_drain_left > 0) begin
      if (m_drain_left == 1) begin
        m_halted = 1;
        m_done   = m_from_step;
      end
      m_drain_left--;
    end else if (m_halted) begin
      if (clear) begin
        m_halted = 0;
        m_flush  = 1;
      end
    end else if (m_stepping) begin
      m_stepping = 0;
      if (halt) begin
        m_drain_left = DRAIN;
        m_from_step  = 1;
      end else begin
        m_done = 1;
      end
    end else if (m_running) begin
      if (halt) begin
        m_running    = 0;
        m_drain_left = DRAIN;
        m_from_step  = 0;
      end else if (stop) begin
        m_running = 0;
      end
    end else begin
      if (clear) m_flush = 1;
      else if (run) m_running = 1;
      else if (step) m_stepping = 1;
    end
    if (m_flush) m_cnt = 0;
    else if (en && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic check_outputs();
    check("state", 64'(o_state), 64'(model_state()));
    check("pipe_enable", 64'(o_pipe_enable), 64'(model_en()));
    check("halted", 64'(o_halted), 64'(m_halted));
    check("pipe_flush", 64'(o_pipe_flush), 64'(m_flush));
    check("step_done", 64'(o_step_done), 64'(m_done));
    check("cycle_cnt", 64'(o_cycle_cnt), 64'(m_cnt));
  endtask

  task automatic cycle(input bit run, input bit step, input bit stop,
                       input bit clear, input bit halt);
    @(negedge i_clk);
    i_cmd_run      = run;
    i_cmd_step     = step;
    i_cmd_stop     = stop;
    i_cmd_clear    = clear;
    i_halt_decoded = halt;
    #1;
    check("fetch_kill", 64'(o_fetch_kill), 64'(model_kill(halt)));
    model_step(run, step, stop, clear, halt);
    @(posedge i_clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Reset asserted away from the clock edge; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge i_clk);
    i_cmd_run = 0; i_cmd_step = 0; i_cmd_stop = 0; i_cmd_clear = 0; i_halt_decoded = 0;
    i_reset = 1;
    #1;
    model_reset();
    check_outputs();
    check("reset_fetch_kill", 64'(o_fetch_kill), 64'd0);
    @(negedge i_clk);
    i_reset = 0;
  endtask

  initial begin
    i_reset = 1;
    i_cmd_run = 0; i_cmd_step = 0; i_cmd_stop = 0; i_cmd_clear = 0; i_halt_decoded = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge i_clk);
    i_reset = 0;

    // Free run for 10 enabled cycles, then stop.
    cycle(1, 0, 0, 0, 0);
    idle(9);
    cycle(0, 0, 1, 0, 0);
    check("run10_cnt", 64'(o_cycle_cnt), 64'd10);
    check("run10_state", 64'(o_state), 64'd0);

    // Clear in IDLE, then three spaced single steps.
    cycle(0, 0, 0, 1, 0);
    check("idle_clear_flush", 64'(o_pipe_flush), 64'd1);
    check("idle_clear_cnt", 64'(o_cycle_cnt), 64'd0);
    for (int s = 0; s < 3; s++) begin
      cycle(0, 1, 0, 0, 0);
      check("step_enable", 64'(o_pipe_enable), 64'd1);
      cycle(0, 0, 0, 0, 0);
      check("step_done_pulse", 64'(o_step_done), 64'd1);
      idle(2);
    end
    check("step3_cnt", 64'(o_cycle_cnt), 64'd3);

    // HALT decoded in the 6th enabled cycle; stop during DRAIN must be ignored.
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    idle(5);
    cycle(0, 0, 0, 0, 1);
    check("halt_to_drain", 64'(o_state), 64'd3);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("halted_flag", 64'(o_halted), 64'd1);
    check("halted_cnt", 64'(o_cycle_cnt), 64'd9);
    check("halted_enable", 64'(o_pipe_enable), 64'd0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("halted_ignores_cmds", 64'(o_state), 64'd4);

    // Clear out of HALTED, then a new run is accepted.
    cycle(0, 0, 0, 1, 0);
    check("halt_clear_flush", 64'(o_pipe_flush), 64'd1);
    check("halt_clear_state", 64'(o_state), 64'd0);
    check("halt_clear_cnt", 64'(o_cycle_cnt), 64'd0);
    cycle(1, 0, 0, 0, 0);
    check("rerun_state", 64'(o_state), 64'd1);

    // stop + halt together in RUN drains; reset lands mid-DRAIN.
    cycle(0, 0, 1, 0, 1);
    check("stop_halt_drain", 64'(o_state), 64'd3);
    cycle(0, 0, 0, 0, 0);
    do_reset();

    // clear + run in IDLE flushes only; a later run restarts from zero.
    cycle(1, 0, 0, 1, 0);
    check("clear_run_flush", 64'(o_pipe_flush), 64'd1);
    check("clear_run_state", 64'(o_state), 64'd0);
    cycle(1, 0, 0, 0, 0);
    check("post_reset_run", 64'(o_state), 64'd1);
    check("post_reset_cnt0", 64'(o_cycle_cnt), 64'd0);
    cycle(0, 0, 0, 0, 0);
    check("post_reset_cnt1", 64'(o_cycle_cnt), 64'd1);
    cycle(0, 0, 1, 0, 0);

    // HALT during a step: step_done pulses together with the halted rise.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    check("step_halt_drain", 64'(o_state), 64'd3);
    idle(2);
    cycle(0, 0, 0, 0, 0);
    check("step_drain_halted", 64'(o_halted), 64'd1);
    check("step_drain_done", 64'(o_step_done), 64'd1);
    cycle(0, 0, 0, 1, 0);

    // Random command traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 6,
              $urandom_range(0, 99) < 10);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
